// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell; purely combinational.
module fulladder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ cin;
  assign c = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first through one fulladder; result valid WIDTH cycles after accept.
// Result holds in DONE until out_ready; operands are refused (in_ready=0) outside IDLE.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_c;

  fulladder u_fa (
    .x   (r_a_sh[0]),
    .y   (r_b_sh[0]),
    .cin (r_carry),
    .s   (w_s),
    .c   (w_c)
  );

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (r_cnt == LAST_BIT) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_carry  <= cin;
            r_cnt    <= '0;
            r_sum_sh <= '0;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
          r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_carry  <= w_c;
          r_cnt    <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum_sh;
  assign cout = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes expected a+b+cin, monitor pops on output handshake.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_acc = 0;
  logic rnd_bp = 1'b0;
  logic prev_ov = 1'b0;

  logic [W:0] exp_q[$];
  int         acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, expv, $time);
    end
  endtask

  // Monitor: latency on out_valid rise, result check on each completed output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) chk("latency_unexpected", 32'(out_valid), 32'd0);
        else chk("latency", 32'(cyc - acc_q.pop_front()), 32'(W));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 32'(out_valid), 32'd0);
        else chk("result", 32'({cout, sum}), 32'(exp_q.pop_front()));
      end
    end
    prev_ov = out_valid;
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the accept edge, leaving in_valid high.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    int k;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 50) begin
        chk("accept_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    exp_q.push_back({1'b0, ta} + {1'b0, tb} + (W+1)'(tc));
    acc_q.push_back(cyc + 1);
    last_acc = cyc + 1;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [W:0] m;
    int first_acc;
    int k;

    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    #20;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add, then a back-to-back op accepted at the earliest legal edge.
    out_ready = 1'b1;
    send(8'h5A, 8'h3C, 1'b0);
    first_acc = last_acc;
    send(8'hFF, 8'h01, 1'b0);
    chk("init_interval", 32'(last_acc - first_acc), 32'(W + 2));
    send(8'hFF, 8'hFF, 1'b1);
    in_valid = 1'b0;
    wait_drain();

    // Backpressure in DONE for 5 edges.
    out_ready = 1'b0;
    send(8'hA7, 8'h6D, 1'b1);
    in_valid = 1'b0;
    m = {1'b0, 8'hA7} + {1'b0, 8'h6D} + 9'd1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 30);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_hold", 32'({cout, sum}), 32'(m));
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_hold", 32'({cout, sum}), 32'(m));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp_back_idle", 32'(in_ready), 32'd1);
    chk("bp_ov_low", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // in_valid held with changing operands during RUN.
    send(8'h12, 8'h34, 1'b1);
    repeat (6) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      @(negedge clk);
      chk("run_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain();

    // Reset mid-RUN at cnt==3 aborts the op.
    send(8'hC3, 8'h5E, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(8'h01, 8'h01, 1'b0);
    in_valid = 1'b0;
    wait_drain();

    // Random operands with random output backpressure.
    rnd_bp = 1'b1;
    for (int i = 0; i < 1000; i++)
      send(8'($urandom), 8'($urandom), 1'($urandom));
    in_valid = 1'b0;
    rnd_bp = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
